// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the register file / write-back queue slice.
package grf_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SRL = 3'b100,
        ALU_SRA = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/grf_wb_fifo.sv
// Write-back queue: circular buffer of {addr,data} entries with every slot
// and its occupancy exposed so the read path can bypass undrained writes.
module grf_wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DATA_W = grf_wb_pkg::DATA_W,
    parameter int ADDR_W = grf_wb_pkg::ADDR_W,
    parameter int QDEPTH = 2,
    localparam int PTR_W = $clog2(QDEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [PTR_W-1:0]  head,
    output logic [ADDR_W-1:0] ent_addr [QDEPTH],
    output logic [DATA_W-1:0] ent_data [QDEPTH],
    output logic [QDEPTH-1:0] valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    logic [PTR_W-1:0] tail;
    logic             pop_ok;

    assign pop_ok    = pop && (count != '0);
    assign head_addr = ent_addr[head];
    assign head_data = ent_data[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_addr[tail] <= push_addr;
                ent_data[tail] <= push_data;
                tail           <= tail + PTR_W'(1);
            end
            if (pop_ok) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is occupied when its distance from head is below the fill count.
    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            valid[i] = ({1'b0, PTR_W'(i) - head} < count);
        end
    end

endmodule

// File: rtl/grf_wb.sv
// 32x32 register file fed by a queued write-back port; reads bypass queued
// entries so ALU operands always reflect every accepted write.
module grf_wb #(
    parameter int DATA_W = grf_wb_pkg::DATA_W,
    parameter int ADDR_W = grf_wb_pkg::ADDR_W,
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      drain_en,
    input  logic [ADDR_W-1:0]         ra1,
    input  logic [ADDR_W-1:0]         ra2,
    output logic [DATA_W-1:0]         rd1,
    output logic [DATA_W-1:0]         rd2,
    output logic [$clog2(QDEPTH):0]   q_count
);
    import grf_wb_pkg::*;

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [ADDR_W-1:0] ent_addr [QDEPTH];
    logic [DATA_W-1:0] ent_data [QDEPTH];
    logic [QDEPTH-1:0] valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              push;
    logic              pop;

    // Ready depends only on registered fill level, never on drain_en.
    assign wb_ready = !reset && (count < CNT_W'(QDEPTH));
    assign push     = wb_valid && wb_ready && (wb_addr != ADDR_W'(REG_ZERO));
    assign pop      = drain_en && (count != '0);
    assign q_count  = count;

    grf_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_addr (wb_addr),
        .push_data (wb_data),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .valid     (valid),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (pop) begin
            regs[head_addr] <= head_data;
        end
    end

    // Walk oldest to youngest so the newest matching entry overrides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = head;
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        for (int unsigned k = 0; k < QDEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (ent_addr[idx] == ra1)) begin
                rd1 = ent_data[idx];
            end
            if (valid[idx] && (ent_addr[idx] == ra2)) begin
                rd2 = ent_data[idx];
            end
        end
        if (ra1 == ADDR_W'(REG_ZERO)) begin
            rd1 = '0;
        end
        if (ra2 == ADDR_W'(REG_ZERO)) begin
            rd2 = '0;
        end
    end

endmodule

// File: tb/tb_grf_wb.sv
// Directed bench for grf_wb: a queue/array model acts as scoreboard for
// write-back acceptance, FIFO drain order and the bypassed read path.
`timescale 1ns/1ps
module tb_grf_wb;
    import grf_wb_pkg::*;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        drain_en = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [1:0]  q_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mregs [32];
    wb_entry_t   mq [$];

    grf_wb #(
        .DATA_W (32),
        .ADDR_W (5),
        .QDEPTH (QD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .drain_en (drain_en),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .q_count  (q_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return 32'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == r) return mq[i].data;
        end
        return mregs[r];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic de);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        drain_en = de;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    // One clock: update the scoreboard with pre-edge state, then check occupancy.
    task automatic cycle(input string tag);
        int        sz;
        wb_entry_t e;
        logic      acc;
        logic      drn;
        @(posedge clk);
        sz  = mq.size();
        acc = wb_valid && (sz < QD);
        drn = drain_en && (sz > 0);
        if (drn) begin
            e = mq.pop_front();
            mregs[e.addr] = e.data;
        end
        if (acc && (wb_addr != 5'd0)) begin
            e.addr = wb_addr;
            e.data = wb_data;
            mq.push_back(e);
        end
        @(negedge clk);
        check({tag, ":q_count"}, 32'(q_count), 32'(mq.size()));
        check({tag, ":wb_ready"}, 32'(wb_ready), 32'(mq.size() < QD));
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] r);
        ra1 = r;
        ra2 = r;
        #1;
        check({tag, ":rd1"}, rd1, model_read(r));
        check({tag, ":rd2"}, rd2, model_read(r));
    endtask

    initial begin
        logic [31:0] res;
        model_reset();

        // Reset holds ready low and the queue empty.
        @(negedge clk);
        check("in_reset:wb_ready", 32'(wb_ready), 32'd0);
        check("in_reset:q_count", 32'(q_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset:wb_ready", 32'(wb_ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #0.1;
            check("reset_sweep:rd1", rd1, 32'd0);
            check("reset_sweep:rd2", rd2, 32'd0);
        end
        @(negedge clk);

        // Single write with drain enabled; not bypassed in its own cycle.
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b1);
        rd_chk("r5_same_cycle", 5'd5);
        check("r5_same_cycle_zero", rd1, 32'd0);
        cycle("w5");
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        rd_chk("r5_queued", 5'd5);
        check("r5_value", rd1, 32'h1234_5678);
        cycle("d5");
        rd_chk("r5_drained", 5'd5);

        // Two writes to r3 without drain; newer wins, queue fills.
        drive(1'b1, 5'd3, 32'd1, 1'b0);
        cycle("w3a");
        drive(1'b1, 5'd3, 32'd2, 1'b0);
        cycle("w3b");
        rd_chk("r3_newer", 5'd3);
        check("r3_is_2", rd1, 32'd2);
        check("full_ready", 32'(wb_ready), 32'd0);

        // Third request stalls while full.
        drive(1'b1, 5'd9, 32'h0000_00AA, 1'b0);
        cycle("stall1");
        cycle("stall2");
        rd_chk("r9_stalled", 5'd9);

        // Drain while request held: pop first, accept the following cycle.
        drive(1'b1, 5'd9, 32'h0000_00AA, 1'b1);
        cycle("full_pop");
        cycle("pop_push");
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        cycle("drain_last");
        rd_chk("r3_final", 5'd3);
        check("r3_final_2", rd1, 32'd2);
        rd_chk("r9_final", 5'd9);
        check("r9_final_aa", rd1, 32'h0000_00AA);

        // Writes to r0 are consumed but never stored.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        cycle("w0");
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        rd_chk("r0", 5'd0);
        check("r0_zero", rd1, 32'd0);

        // Reset mid-cycle discards queued writes and clears the array.
        drive(1'b1, 5'd10, 32'h0000_000A, 1'b0);
        cycle("w10");
        drive(1'b1, 5'd11, 32'h0000_000B, 1'b0);
        cycle("w11");
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        rd_chk("r10_queued", 5'd10);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_reset:q_count", 32'(q_count), 32'd0);
        check("mid_reset:wb_ready", 32'(wb_ready), 32'd0);
        rd_chk("mid_reset_r10", 5'd10);
        rd_chk("mid_reset_r11", 5'd11);
        rd_chk("mid_reset_r3", 5'd3);
        rd_chk("mid_reset_r5", 5'd5);
        @(negedge clk);
        reset = 1'b0;
        cycle("post_mid_reset");

        // ALU round trip: SRA of r1 by r2 written back to r7.
        drive(1'b1, 5'd1, 32'h8000_0000, 1'b1);
        cycle("w1");
        drive(1'b1, 5'd2, 32'd4, 1'b1);
        cycle("w2");
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        cycle("d2");
        ra1 = 5'd1;
        ra2 = 5'd2;
        #1;
        check("alu_a", rd1, 32'h8000_0000);
        check("alu_b", rd2, 32'd4);
        res = alu(ALU_SRA, rd1, rd2);
        @(negedge clk);
        drive(1'b1, 5'd7, res, 1'b1);
        cycle("w7");
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        rd_chk("r7_queued", 5'd7);
        check("r7_sra", rd1, 32'hF800_0000);
        cycle("d7");
        rd_chk("r7_array", 5'd7);
        check("r7_sra_array", rd2, 32'hF800_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
